// File: rtl/smi_phy_manager.sv
// Sequences MDIO transactions for one PHY: a BMCR write after reset, periodic
// BMSR polls that publish link status, and single host accesses in between.
module smi_phy_manager #(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [15:0] INIT_BMCR   = 16'h1200,
  parameter int unsigned POLL_CYCLES = 1000000,
  parameter int unsigned REQ_HOLD    = 256,
  parameter int unsigned XFER_CYCLES = 4608
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [4:0]  host_reg,
  input  logic [15:0] host_wdata,
  output logic        host_busy,
  output logic        host_done,
  output logic [15:0] host_rdata,
  output logic        host_err,
  output logic [4:0]  smi_phy_addr,
  output logic [4:0]  smi_reg_addr,
  output logic [15:0] smi_wdata,
  output logic        smi_do_read,
  output logic        smi_do_write,
  input  logic [15:0] smi_rdata,
  input  logic        smi_rdata_valid,
  output logic [15:0] bmsr,
  output logic        link_up,
  output logic        an_done,
  output logic        status_valid
);

  localparam int unsigned TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned CNT_W = $clog2(XFER_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REQ_HOLD - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_XFER, S_DONE} state_t;
  typedef enum logic [1:0] {TAG_INIT, TAG_POLL, TAG_HOST} tag_t;

  state_t             state_q;
  tag_t               tag_q;
  logic               we_q;
  logic [4:0]         phy_q;
  logic [4:0]         reg_q;
  logic [15:0]        wdata_q;
  logic               rd_q;
  logic               wr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pend_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        hrdata_q;
  logic               herr_q;
  logic [15:0]        bmsr_q;
  logic               sv_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [TMR_W-1:0]   tmr_d;
  logic               wrap;

  // Free-running poll timer; it keeps counting while transactions are in flight.
  always_comb begin
    wrap  = (tmr_q == TMR_LAST);
    tmr_d = wrap ? '0 : tmr_q + TMR_W'(1);
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      tag_q    <= TAG_INIT;
      we_q     <= 1'b0;
      phy_q    <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      hrdata_q <= '0;
      herr_q   <= 1'b0;
      bmsr_q   <= '0;
      sv_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          tag_q   <= TAG_INIT;
          we_q    <= 1'b1;
          phy_q   <= PHY_ADDR;
          reg_q   <= 5'd0;
          wdata_q <= INIT_BMCR;
          wr_q    <= 1'b1;
          rd_q    <= 1'b0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_XFER;
        end
        S_IDLE: begin
          // Host has priority; a pending poll simply waits for the next IDLE.
          if (host_req) begin
            tag_q   <= TAG_HOST;
            we_q    <= host_we;
            phy_q   <= PHY_ADDR;
            reg_q   <= host_reg;
            wdata_q <= host_wdata;
            wr_q    <= host_we;
            rd_q    <= !host_we;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_XFER;
          end else if (pend_q) begin
            tag_q   <= TAG_POLL;
            we_q    <= 1'b0;
            phy_q   <= PHY_ADDR;
            reg_q   <= 5'd1;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b1;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == HOLD_LAST) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
          end
          if (cnt_q == XFER_LAST) state_q <= S_DONE;
        end
        S_DONE: begin
          case (tag_q)
            TAG_POLL: begin
              if (smi_rdata_valid) begin
                bmsr_q <= smi_rdata;
                sv_q   <= 1'b1;
              end
            end
            TAG_HOST: begin
              done_q <= 1'b1;
              if (we_q) begin
                herr_q <= 1'b0;
              end else begin
                hrdata_q <= smi_rdata;
                herr_q   <= !smi_rdata_valid;
              end
            end
            default: ;
          endcase
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
      // A wrap that lands while a poll is already pending collapses into it.
      if (wrap) pend_q <= 1'b1;
    end
  end

  assign host_busy    = busy_q;
  assign host_done    = done_q;
  assign host_rdata   = hrdata_q;
  assign host_err     = herr_q;
  assign smi_phy_addr = phy_q;
  assign smi_reg_addr = reg_q;
  assign smi_wdata    = wdata_q;
  assign smi_do_read  = rd_q;
  assign smi_do_write = wr_q;
  assign bmsr         = bmsr_q;
  assign link_up      = bmsr_q[2];
  assign an_done      = bmsr_q[5];
  assign status_valid = sv_q;

endmodule

// File: tb/tb_smi_phy_manager.sv
// Scoreboard bench for smi_phy_manager with a behavioural MDIO serializer model.
module tb_smi_phy_manager;

  localparam int POLL = 10000;
  localparam int XFER = 4608;
  localparam int HOLD = 256;

  logic        clk_100mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [4:0]  host_reg = '0;
  logic [15:0] host_wdata = '0;
  logic        host_busy, host_done, host_err;
  logic [15:0] host_rdata;
  logic [4:0]  smi_phy_addr, smi_reg_addr;
  logic [15:0] smi_wdata;
  logic        smi_do_read, smi_do_write;
  logic [15:0] smi_rdata = '0;
  logic        smi_rdata_valid = 1'b0;
  logic [15:0] bmsr;
  logic        link_up, an_done, status_valid;

  smi_phy_manager #(.POLL_CYCLES(POLL)) dut (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_reg(host_reg), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_done(host_done), .host_rdata(host_rdata), .host_err(host_err),
    .smi_phy_addr(smi_phy_addr), .smi_reg_addr(smi_reg_addr), .smi_wdata(smi_wdata),
    .smi_do_read(smi_do_read), .smi_do_write(smi_do_write),
    .smi_rdata(smi_rdata), .smi_rdata_valid(smi_rdata_valid),
    .bmsr(bmsr), .link_up(link_up), .an_done(an_done), .status_valid(status_valid)
  );

  initial forever #5 clk_100mhz = ~clk_100mhz;

  int unsigned cyc = 0;
  initial forever begin
    @(posedge clk_100mhz);
    cyc++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rg;
    logic [15:0] wd;
    int unsigned c;
  } txn_t;

  typedef struct {
    logic [15:0] rd;
    logic        err;
    int unsigned c;
  } hexp_t;

  txn_t  obs_q[$];
  hexp_t hq[$];

  // Serializer behaviour and expected link status
  logic [15:0] mdl_bmsr = 16'h7829;
  logic        mdl_bvld = 1'b1;
  logic [15:0] mdl_hval = '0;
  logic        mdl_hvld = 1'b1;
  logic [15:0] exp_hrd = '0;

  // Serializer model: records each transaction, answers reads, tracks BMSR expectations.
  initial begin
    logic        prev;
    int          len;
    txn_t        cur;
    logic [15:0] exp_bmsr;
    logic        exp_sv;
    bit          pend_act;
    int unsigned pend_cyc;
    logic [15:0] pend_val;
    logic        pend_vld;
    prev = 1'b0; len = 0; exp_bmsr = '0; exp_sv = 1'b0; pend_act = 0;
    pend_cyc = 0; pend_val = '0; pend_vld = 1'b0;
    cur = '{we: 1'b0, rg: 5'd0, wd: 16'd0, c: 0};
    forever begin
      @(negedge clk_100mhz);
      if (!rst_n) begin
        prev = 1'b0; len = 0; pend_act = 0; exp_bmsr = '0; exp_sv = 1'b0;
      end else begin
        if ((smi_do_read || smi_do_write) && !prev) begin
          cur = '{we: smi_do_write, rg: smi_reg_addr, wd: smi_wdata, c: cyc};
          obs_q.push_back(cur);
          chk("phy_addr", 32'(smi_phy_addr), 32'd1);
          if (smi_do_read) begin
            if (smi_reg_addr == 5'd1) begin
              smi_rdata = mdl_bmsr; smi_rdata_valid = mdl_bvld;
              pend_act = 1; pend_cyc = cyc + XFER + 1; pend_val = mdl_bmsr; pend_vld = mdl_bvld;
            end else begin
              smi_rdata = mdl_hval; smi_rdata_valid = mdl_hvld;
            end
          end
          len = 0;
        end
        if (smi_do_read || smi_do_write) begin
          len++;
        end else if (prev) begin
          chk("strobe_len", 32'(len), 32'(HOLD));
          chk("reg_hold", {11'd0, smi_reg_addr, smi_wdata}, {11'd0, cur.rg, cur.wd});
        end
        prev = smi_do_read || smi_do_write;
        if (pend_act && cyc == pend_cyc - 1)
          chk("bmsr_before_done", 32'(bmsr), 32'(exp_bmsr));
        if (pend_act && cyc == pend_cyc) begin
          if (pend_vld) begin
            exp_bmsr = pend_val;
            exp_sv = 1'b1;
          end
          chk("bmsr", 32'(bmsr), 32'(exp_bmsr));
          chk("link_up", 32'(link_up), 32'(exp_bmsr[2]));
          chk("an_done", 32'(an_done), 32'(exp_bmsr[5]));
          chk("status_valid", 32'(status_valid), 32'(exp_sv));
          pend_act = 0;
        end
      end
    end
  end

  // Host response monitor
  initial begin
    hexp_t e;
    forever begin
      @(negedge clk_100mhz);
      if (rst_n && host_done) begin
        if (hq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL host_done_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else begin
          e = hq.pop_front();
          chk("host_rdata", 32'(host_rdata), 32'(e.rd));
          chk("host_err", 32'(host_err), 32'(e.err));
          chk("host_latency", cyc - e.c, 32'(XFER + 1));
        end
      end
    end
  end

  task automatic wait_idle(input int lim);
    int n = 0;
    while (host_busy && n < lim) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("idle_timeout", 32'(host_busy), 32'd0);
  endtask

  task automatic get_txn(output txn_t t, input int lim);
    int n = 0;
    while (obs_q.size() == 0 && n < lim) begin
      @(negedge clk_100mhz);
      n++;
    end
    if (obs_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL txn_timeout: got no transaction expected one within %0d cycles", lim);
      t = '{we: 1'b0, rg: 5'd0, wd: 16'd0, c: 0};
    end else begin
      t = obs_q.pop_front();
    end
  endtask

  // Host never targets reg 1, so reg-1 reads seen here are polls and may be skipped.
  task automatic get_host_txn(output txn_t t);
    get_txn(t, 3 * POLL);
    while (!t.we && t.rg == 5'd1 && obs_q.size() > 0) t = obs_q.pop_front();
  endtask

  task automatic chk_txn(input string name, input txn_t t, input logic we,
                         input logic [4:0] rg, input logic [15:0] wd);
    chk({name, "_op"}, 32'(t.we), 32'(we));
    chk({name, "_reg"}, 32'(t.rg), 32'(rg));
    if (we) chk({name, "_wdata"}, 32'(t.wd), 32'(wd));
  endtask

  task automatic host_op(input logic we, input logic [4:0] rg, input logic [15:0] wd);
    hexp_t e;
    host_we = we; host_reg = rg; host_wdata = wd; host_req = 1'b1;
    e.rd  = we ? exp_hrd : mdl_hval;
    e.err = we ? 1'b0 : !mdl_hvld;
    e.c   = cyc + 1;
    exp_hrd = e.rd;
    hq.push_back(e);
    @(negedge clk_100mhz);
    host_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t        t, t2;
    int unsigned rel, tgt;
    logic        we;
    logic [4:0]  rg;
    logic [15:0] wd;

    repeat (3) @(negedge clk_100mhz);
    chk("rst_busy", 32'(host_busy), 32'd1);
    chk("rst_strobes", {30'd0, smi_do_read, smi_do_write}, 32'd0);
    chk("rst_status", {15'd0, status_valid, bmsr}, 32'd0);
    chk("rst_done", 32'(host_done), 32'd0);
    rst_n = 1'b1;
    rel = cyc;

    // BMCR write after reset release
    get_txn(t, 20);
    chk_txn("init", t, 1'b1, 5'd0, 16'h1200);
    chk("init_start", t.c - rel, 32'd1);
    wait_idle(XFER + 10);
    chk("init_busy_len", cyc - t.c, 32'(XFER + 1));

    // First poll; a host request while it runs must be dropped
    get_txn(t, 2 * POLL);
    chk_txn("poll1", t, 1'b0, 5'd1, 16'h0);
    host_we = 1'b1; host_reg = 5'd5; host_wdata = 16'hBEEF; host_req = 1'b1;
    @(negedge clk_100mhz);
    host_req = 1'b0;
    mdl_bmsr = 16'h782D;
    wait_idle(XFER + 10);

    mdl_hval = 16'h0022; mdl_hvld = 1'b1;
    host_op(1'b0, 5'd2, 16'h0);
    get_host_txn(t);
    chk_txn("hread2", t, 1'b0, 5'd2, 16'h0);
    wait_idle(XFER + 10);

    get_txn(t, 2 * POLL);
    chk_txn("poll2", t, 1'b0, 5'd1, 16'h0);
    wait_idle(XFER + 10);

    // Host write issued on the exact cycle the poll timer wraps
    mdl_bmsr = 16'($urandom);
    tgt = rel + ((cyc - rel) / POLL + 1) * POLL;
    while (cyc < tgt - 1) @(negedge clk_100mhz);
    chk("idle_at_wrap", 32'(host_busy), 32'd0);
    host_op(1'b1, 5'd4, 16'h01E1);
    get_txn(t, 20);
    chk_txn("wrap_write", t, 1'b1, 5'd4, 16'h01E1);
    get_txn(t2, XFER + 20);
    chk_txn("wrap_poll", t2, 1'b0, 5'd1, 16'h0);
    chk("wrap_poll_gap", t2.c - t.c, 32'(XFER + 2));
    wait_idle(XFER + 10);

    // Invalid read data: poll leaves status untouched, host read reports error
    mdl_bvld = 1'b0;
    mdl_bmsr = ~16'($urandom);
    get_txn(t, 2 * POLL);
    chk_txn("poll_inv", t, 1'b0, 5'd1, 16'h0);
    wait_idle(XFER + 10);
    mdl_hval = 16'($urandom); mdl_hvld = 1'b0;
    rg = 5'($urandom_range(31, 2));
    host_op(1'b0, rg, 16'h0);
    get_host_txn(t);
    chk_txn("hread_inv", t, 1'b0, rg, 16'h0);
    wait_idle(XFER + 10);
    mdl_bvld = 1'b1;

    for (int i = 0; i < 2; i++) begin
      we = 1'($urandom);
      rg = 5'($urandom_range(31, 2));
      wd = 16'($urandom);
      mdl_hval = 16'($urandom);
      mdl_hvld = 1'($urandom);
      mdl_bmsr = 16'($urandom);
      host_op(we, rg, wd);
      get_host_txn(t);
      chk_txn("hrand", t, we, rg, wd);
      wait_idle(XFER + 10);
    end

    // Reset in the middle of a host read
    mdl_hval = 16'($urandom); mdl_hvld = 1'b1;
    host_op(1'b0, 5'd3, 16'h0);
    get_host_txn(t);
    chk_txn("hread_rst", t, 1'b0, 5'd3, 16'h0);
    while (cyc < t.c + 1000) @(negedge clk_100mhz);
    rst_n = 1'b0;
    #1;
    if (hq.size() > 0) void'(hq.pop_back());
    exp_hrd = '0;
    chk("arst_busy", 32'(host_busy), 32'd1);
    chk("arst_strobes", {30'd0, smi_do_read, smi_do_write}, 32'd0);
    chk("arst_host", {14'd0, host_done, host_err, host_rdata}, 32'd0);
    chk("arst_status", {13'd0, link_up, an_done, status_valid, bmsr}, 32'd0);
    chk("arst_smi", {6'd0, smi_phy_addr, smi_reg_addr, smi_wdata}, 32'd0);
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;
    rel = cyc;
    get_txn(t, 20);
    chk_txn("reinit", t, 1'b1, 5'd0, 16'h1200);
    chk("reinit_start", t.c - rel, 32'd1);
    wait_idle(XFER + 10);
    repeat (5) @(negedge clk_100mhz);
    chk("sb_empty", 32'(hq.size()), 32'd0);
    chk("no_extra_txn", 32'(obs_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
